// File: rtl/radio_pkg.sv
// Shared types and constants for the radio-side link responder.
// Both serial FSMs use the same four-phase frame state encoding.
package radio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } link_state_t;

  localparam int   BIT_CNT_W   = 3;
  localparam logic SERIAL_IDLE = 1'b1;

endpackage

// File: rtl/radio_link_if.sv
// Controller <-> radio request/busy handshake. The shared data bus stays a
// plain inout port on the radio so tri-state resolution is explicit.
interface radio_link_if;

  logic radio_enable;
  logic radio_send;
  logic radio_receive;
  logic radio_busy;

  modport master (
    output radio_enable,
    output radio_send,
    output radio_receive,
    input  radio_busy
  );

  modport slave (
    input  radio_enable,
    input  radio_send,
    input  radio_receive,
    output radio_busy
  );

endinterface

// File: rtl/radio_rx_fifo.sv
// Small byte FIFO for received serial data; the head is readable without
// latency so the controller can sample it at the pop edge.
module radio_rx_fifo #(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam int             AW       = $clog2(RX_DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(RX_DEPTH);

  logic [7:0]    r_mem [RX_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A pop frees the slot being written, so a full FIFO still accepts a push then.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/radio_link.sv
// Radio-side responder: serializes controller bytes onto an 8N1 line and
// deserializes incoming 8N1 frames into a FIFO read back over the shared bus.
module radio_link
  import radio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int RX_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  radio_link_if.slave  bus,
  inout  wire  [7:0]   io_radio_data,
  output logic         o_tx_serial,
  input  logic         i_rx_serial,
  output logic         o_rx_overflow,
  output logic         o_rx_frame_err
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic w_rd_req;
  logic w_tx_req;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic [7:0] w_head;

  assign w_rd_req = bus.radio_enable & bus.radio_receive & ~bus.radio_send;
  assign w_tx_req = bus.radio_enable & bus.radio_send & ~bus.radio_receive;
  assign w_pop    = w_rd_req & ~w_empty;

  // ---------------- transmit ----------------
  link_state_t          r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [BIT_CNT_W-1:0] r_tx_bit;
  logic [7:0]           r_tx_shift;
  logic                 r_tx_armed;
  logic                 r_tx_serial;
  logic                 w_tx_serial_next;
  logic                 w_tx_active;
  logic                 w_tx_tick;
  logic                 w_tx_accept;

  assign w_tx_active = (r_tx_state != ST_IDLE);
  assign w_tx_tick   = (r_tx_cnt == CNT_LAST);
  assign w_tx_accept = w_tx_req & ~w_tx_active & r_tx_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= ST_IDLE;
    else        r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      ST_IDLE:  if (w_tx_accept) w_tx_state_next = ST_START;
      ST_START: if (w_tx_tick)   w_tx_state_next = ST_DATA;
      ST_DATA:  if (w_tx_tick && r_tx_bit == '1) w_tx_state_next = ST_STOP;
      ST_STOP:  if (w_tx_tick)   w_tx_state_next = ST_IDLE;
      default:  w_tx_state_next = ST_IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so the output stays registered.
  always_comb begin
    w_tx_serial_next = SERIAL_IDLE;
    case (w_tx_state_next)
      ST_START: w_tx_serial_next = 1'b0;
      ST_DATA:  w_tx_serial_next = (r_tx_state == ST_DATA && w_tx_tick) ?
                                   r_tx_shift[1] : r_tx_shift[0];
      default:  w_tx_serial_next = SERIAL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_tx_armed  <= 1'b1;
      r_tx_serial <= SERIAL_IDLE;
    end else begin
      r_tx_serial <= w_tx_serial_next;
      r_tx_cnt    <= (r_tx_state == ST_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      if (!bus.radio_send) r_tx_armed <= 1'b1;
      else if (w_tx_accept) r_tx_armed <= 1'b0;
      if (w_tx_accept) begin
        r_tx_shift <= io_radio_data;
        r_tx_bit   <= '0;
      end else if (r_tx_state == ST_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end
  end

  assign o_tx_serial = r_tx_serial;

  // ---------------- receive ----------------
  link_state_t          r_rx_state, w_rx_state_next;
  logic [1:0]           r_rx_sync;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [BIT_CNT_W-1:0] r_rx_bit;
  logic [7:0]           r_rx_shift;
  logic                 r_rx_overflow;
  logic                 r_rx_frame_err;
  logic                 w_rx_line;
  logic                 w_rx_half;
  logic                 w_rx_tick;
  logic                 w_rx_data_sample;
  logic                 w_rx_stop_sample;
  logic                 w_rx_push;

  assign w_rx_line = r_rx_sync[1];
  assign w_rx_half = (r_rx_cnt == CNT_HALF);
  assign w_rx_tick = (r_rx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= ST_IDLE;
    else        r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      ST_IDLE:  if (!w_rx_line) w_rx_state_next = ST_START;
      ST_START: if (w_rx_half)  w_rx_state_next = w_rx_line ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_rx_tick && r_rx_bit == '1) w_rx_state_next = ST_STOP;
      ST_STOP:  if (w_rx_tick)  w_rx_state_next = ST_IDLE;
      default:  w_rx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rx_data_sample = (r_rx_state == ST_DATA) & w_rx_tick;
    w_rx_stop_sample = (r_rx_state == ST_STOP) & w_rx_tick;
    w_rx_push        = w_rx_stop_sample & w_rx_line;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync      <= {2{SERIAL_IDLE}};
      r_rx_cnt       <= '0;
      r_rx_bit       <= '0;
      r_rx_shift     <= '0;
      r_rx_overflow  <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], i_rx_serial};
      if (r_rx_state == ST_IDLE || (r_rx_state == ST_START && w_rx_half) || w_rx_tick)
        r_rx_cnt <= '0;
      else
        r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == ST_START) begin
        r_rx_bit <= '0;
      end else if (w_rx_data_sample) begin
        r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      r_rx_overflow  <= w_rx_push & w_full & ~w_pop;
      r_rx_frame_err <= w_rx_stop_sample & ~w_rx_line;
    end
  end

  assign o_rx_overflow  = r_rx_overflow;
  assign o_rx_frame_err = r_rx_frame_err;

  radio_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // ---------------- controller side ----------------
  assign bus.radio_busy = w_tx_active | (bus.radio_enable & bus.radio_receive & w_empty);
  assign io_radio_data  = w_rd_req ? w_head : 8'hzz;

endmodule

// File: tb/tb_radio_link.sv
// Scoreboard bench for radio_link: stimulus queues expected TX frames, pops
// and error pulses; independent monitors compare what the DUT presents.
module tb_radio_link;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radio_link_if bus ();
  wire  [7:0] radio_data;
  logic [7:0] tb_data;
  logic       tb_drive;
  logic       tx_serial;
  logic       rx_serial;
  logic       rx_overflow;
  logic       rx_frame_err;

  assign radio_data = tb_drive ? tb_data : 8'hzz;

  radio_link #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .io_radio_data  (radio_data),
    .o_tx_serial    (tx_serial),
    .i_rx_serial    (rx_serial),
    .o_rx_overflow  (rx_overflow),
    .o_rx_frame_err (rx_frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         exp_ev[$];   // 1 = overflow pulse, 2 = frame error pulse
  logic       tx_mon_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT produced an event with nothing queued", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    step(CPB);
    for (int k = 0; k < 8; k++) begin
      rx_serial = b[k];
      step(CPB);
    end
    rx_serial = stop_bit;
    step(CPB);
    rx_serial = 1'b1;
  endtask

  task automatic tx_request(input logic [7:0] b);
    exp_tx.push_back(b);
    bus.radio_enable = 1'b1;
    bus.radio_send   = 1'b1;
    tb_drive = 1'b1;
    tb_data  = b;
    step(1);
    bus.radio_enable = 1'b0;
    bus.radio_send   = 1'b0;
    tb_drive = 1'b0;
  endtask

  // TX monitor: captures 40 cycles of line and busy from the start bit onward.
  initial begin
    logic [39:0] wave;
    logic [39:0] busy_v;
    logic [39:0] exp_w;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (rst_n && tx_mon_en && tx_serial == 1'b0) begin
        wave[0]   = tx_serial;
        busy_v[0] = bus.radio_busy;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          wave[i]   = tx_serial;
          busy_v[i] = bus.radio_busy;
        end
        @(negedge clk);
        check("tx_busy_after_frame", 64'(bus.radio_busy), 64'd0);
        check("tx_busy_during_frame", 64'(busy_v), 64'h00FF_FFFF_FFFF);
        if (exp_tx.size() == 0) begin
          unexpected("tx_frame");
        end else begin
          b = exp_tx.pop_front();
          for (int i = 0; i < 40; i++) begin
            if (i < 4)       exp_w[i] = 1'b0;
            else if (i < 36) exp_w[i] = b[(i - 4) / 4];
            else             exp_w[i] = 1'b1;
          end
          check("tx_wave", 64'(wave), 64'(exp_w));
          $display("tx frame 0x%02h: wave %010h", b, wave);
        end
      end
    end
  end

  // Pop monitor: a pop happens at the next rising edge when these hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.radio_enable && bus.radio_receive && !bus.radio_send && !bus.radio_busy) begin
        if (exp_rx.size() == 0) unexpected("rx_pop");
        else begin
          $display("rx pop: data 0x%02h", radio_data);
          check("rx_pop_data", 64'(radio_data), 64'(exp_rx.pop_front()));
        end
      end
    end
  end

  // Error-pulse monitor: a pulse longer than one cycle shows up as an extra event.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_overflow) begin
        $display("rx overflow pulse");
        if (exp_ev.size() == 0) unexpected("rx_overflow");
        else check("rx_event_overflow", 64'd1, 64'(exp_ev.pop_front()));
      end
      if (rx_frame_err) begin
        $display("rx frame error pulse");
        if (exp_ev.size() == 0) unexpected("rx_frame_err");
        else check("rx_event_frame_err", 64'd2, 64'(exp_ev.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.radio_enable  = 1'b0;
    bus.radio_send    = 1'b0;
    bus.radio_receive = 1'b0;
    tb_drive  = 1'b0;
    tb_data   = 8'h00;
    rx_serial = 1'b1;

    // Reset state
    step(3);
    check("reset_tx_serial", 64'(tx_serial), 64'd1);
    check("reset_busy", 64'(bus.radio_busy), 64'd0);
    check("reset_overflow", 64'(rx_overflow), 64'd0);
    check("reset_frame_err", 64'(rx_frame_err), 64'd0);
    rst_n = 1'b1;
    step(2);
    bus.radio_enable  = 1'b1;
    bus.radio_receive = 1'b1;
    #1;
    check("reset_fifo_empty_busy", 64'(bus.radio_busy), 64'd1);
    bus.radio_enable  = 1'b0;
    bus.radio_receive = 1'b0;
    step(2);

    // Transmit 0xA5
    tx_request(8'hA5);
    step(45);

    // Receive 0x3C and pop it
    exp_rx.push_back(8'h3C);
    rx_frame(8'h3C, 1'b1);
    step(4);
    bus.radio_enable  = 1'b1;
    bus.radio_receive = 1'b1;
    @(negedge clk);
    check("rx_busy_at_pop", 64'(bus.radio_busy), 64'd0);
    step(1);
    check("rx_busy_after_pop", 64'(bus.radio_busy), 64'd1);
    bus.radio_enable  = 1'b0;
    bus.radio_receive = 1'b0;
    step(2);

    // Overflow: five frames into a four-deep FIFO
    for (int v = 1; v <= 5; v++) begin
      if (v < 5) exp_rx.push_back(8'(v));
      else       exp_ev.push_back(1);
      rx_frame(8'(v), 1'b1);
    end
    step(4);
    bus.radio_enable  = 1'b1;
    bus.radio_receive = 1'b1;
    step(4);
    check("ovf_fifo_drained", 64'(bus.radio_busy), 64'd1);
    bus.radio_enable  = 1'b0;
    bus.radio_receive = 1'b0;
    step(2);

    // Framing error, then a one-cycle glitch
    exp_ev.push_back(2);
    rx_frame(8'h55, 1'b0);
    step(6);
    bus.radio_enable  = 1'b1;
    bus.radio_receive = 1'b1;
    #1;
    check("ferr_fifo_empty", 64'(bus.radio_busy), 64'd1);
    rx_serial = 1'b0;
    step(1);
    rx_serial = 1'b1;
    step(20);
    check("glitch_no_push", 64'(bus.radio_busy), 64'd1);
    bus.radio_enable  = 1'b0;
    bus.radio_receive = 1'b0;
    step(2);

    // Held send: one frame only, re-arm after a one-cycle drop
    exp_tx.push_back(8'h5A);
    bus.radio_enable = 1'b1;
    bus.radio_send   = 1'b1;
    tb_drive = 1'b1;
    tb_data  = 8'h5A;
    step(1);
    tb_data  = 8'hC3;
    step(59);
    check("held_send_idle", 64'(bus.radio_busy), 64'd0);
    step(40);
    bus.radio_send = 1'b0;
    step(1);
    exp_tx.push_back(8'hC3);
    bus.radio_send = 1'b1;
    step(5);
    bus.radio_send   = 1'b0;
    bus.radio_enable = 1'b0;
    tb_drive = 1'b0;
    step(45);

    // Reset mid-frame with a byte waiting in the FIFO
    rx_frame(8'h77, 1'b1);
    step(4);
    tx_mon_en = 1'b0;
    bus.radio_enable = 1'b1;
    bus.radio_send   = 1'b1;
    tb_drive = 1'b1;
    tb_data  = 8'h00;
    step(1);
    bus.radio_enable = 1'b0;
    bus.radio_send   = 1'b0;
    tb_drive = 1'b0;
    step(10);
    check("rst_pre_tx_low", 64'(tx_serial), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx_serial", 64'(tx_serial), 64'd1);
    check("rst_async_busy", 64'(bus.radio_busy), 64'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    tx_mon_en = 1'b1;
    bus.radio_enable  = 1'b1;
    bus.radio_receive = 1'b1;
    #1;
    check("rst_fifo_discarded", 64'(bus.radio_busy), 64'd1);
    bus.radio_enable  = 1'b0;
    bus.radio_receive = 1'b0;
    step(5);

    check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    check("rx_queue_drained", 64'(exp_rx.size()), 64'd0);
    check("event_queue_drained", 64'(exp_ev.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
